// File: rtl/cache_control_if.sv
// CPU-side and pmem-side request/response handshakes of the L1 cache controller.
// master is the controller's view; slave is the CPU/pmem environment's view.
interface cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  modport master (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control.sv
// Sequencer for a 2-way set-associative write-back L1: hit/miss handling, writeback,
// refill, per-set LRU and hit/miss statistics.
module cache_control #(
  parameter  int NUM_SETS = 8,
  parameter  int CNT_W    = 32,
  localparam int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_control_if.master   bus,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic              hit0,
  input  logic              hit1,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              dirty0,
  input  logic              dirty1,
  output logic              way_sel,
  output logic              data_load0,
  output logic              data_load1,
  output logic              tag_load0,
  output logic              tag_load1,
  output logic              valid_load0,
  output logic              valid_load1,
  output logic              dirty_set0,
  output logic              dirty_set1,
  output logic              dirty_clr0,
  output logic              dirty_clr1,
  output logic              data_src_sel,
  output logic              pmem_addr_sel,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e                state_q, state_d;
  logic [NUM_SETS-1:0]   lru_q, lru_d;
  logic                  victim_q, victim_d;
  logic                  refill_q, refill_d;
  logic [CNT_W-1:0]      hit_count_q, hit_count_d;
  logic [CNT_W-1:0]      miss_count_q, miss_count_d;

  logic [1:0] data_load, tag_load, valid_load, dirty_set, dirty_clr;
  logic       any_hit, hit_way, miss_victim, victim_dirty;

  // Victim preference: an invalid way first, otherwise the LRU way of the set.
  always_comb begin
    any_hit = hit0 | hit1;
    hit_way = ~hit0;
    if (!valid0)      miss_victim = 1'b0;
    else if (!valid1) miss_victim = 1'b1;
    else              miss_victim = lru_q[set_idx];
    victim_dirty = miss_victim ? (valid1 & dirty1) : (valid0 & dirty0);
  end

  always_comb begin
    state_d        = state_q;
    lru_d          = lru_q;
    victim_d       = victim_q;
    refill_d       = refill_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    bus.mem_resp   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    way_sel        = 1'b0;
    data_src_sel   = 1'b0;
    pmem_addr_sel  = 1'b0;
    data_load      = 2'b00;
    tag_load       = 2'b00;
    valid_load     = 2'b00;
    dirty_set      = 2'b00;
    dirty_clr      = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) state_d = COMPARE;
      end
      COMPARE: begin
        refill_d = 1'b0;
        if (any_hit) begin
          way_sel          = hit_way;
          bus.mem_resp     = 1'b1;
          lru_d[set_idx]   = ~hit_way;
          if (bus.mem_write) begin
            data_load[hit_way] = 1'b1;
            dirty_set[hit_way] = 1'b1;
          end
          if (!refill_q) hit_count_d = hit_count_q + CNT_W'(1);
          state_d = IDLE;
        end else begin
          victim_d = miss_victim;
          if (!refill_q) miss_count_d = miss_count_q + CNT_W'(1);
          state_d = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        way_sel        = victim_q;
        pmem_addr_sel  = 1'b1;
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) begin
          dirty_clr[victim_q] = 1'b1;
          state_d             = ALLOCATE;
        end
      end
      ALLOCATE: begin
        way_sel       = victim_q;
        bus.pmem_read = 1'b1;
        // The refilled line is re-compared so the normal hit path finishes the access.
        if (bus.pmem_resp) begin
          data_src_sel         = 1'b1;
          data_load[victim_q]  = 1'b1;
          tag_load[victim_q]   = 1'b1;
          valid_load[victim_q] = 1'b1;
          dirty_clr[victim_q]  = 1'b1;
          refill_d             = 1'b1;
          state_d              = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lru_q        <= '0;
      victim_q     <= 1'b0;
      refill_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lru_q        <= lru_d;
      victim_q     <= victim_d;
      refill_q     <= refill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign data_load0  = data_load[0];
  assign data_load1  = data_load[1];
  assign tag_load0   = tag_load[0];
  assign tag_load1   = tag_load[1];
  assign valid_load0 = valid_load[0];
  assign valid_load1 = valid_load[1];
  assign dirty_set0  = dirty_set[0];
  assign dirty_set1  = dirty_set[1];
  assign dirty_clr0  = dirty_clr[0];
  assign dirty_clr1  = dirty_clr[1];
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing controller for the 2-way set-associative, write-back L1 data cache. It sits between the CPU memory port and physical memory, and drives the load/select strobes of the cache datapath. That datapath includes the byte-merging write path, which combines CPU write data into a 256-bit line under `mem_byte_enable`. The block holds per-set LRU state and hit/miss statistics, and owns the CPU and pmem handshakes.

## Interface
- `NUM_SETS`, 8: sets per way; `IDX_W = $clog2(NUM_SETS)`.
- `CNT_W`, 32: width of the hit and miss counters.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read`, `mem_write` in 1 each: CPU requests, level-held until `mem_resp`.
- `mem_resp` out 1: one-cycle CPU completion pulse.
- `set_idx` in IDX_W: set index of the current CPU address.
- `hit0`, `hit1` in 1 each: tag match AND valid, per way, from the tag compare.
- `valid0`, `valid1`, `dirty0`, `dirty1` in 1 each: array bits of the indexed set.
- `pmem_read`, `pmem_write` out 1 each: pmem requests, held until `pmem_resp`.
- `pmem_resp` in 1: pmem completion pulse.
- `way_sel` out 1: way driving cachemux and receiving writes.
- `data_load0`, `data_load1` out 1 each: data array write enables.
- `tag_load0`, `tag_load1` out 1 each: tag array write enables.
- `valid_load0`, `valid_load1` out 1 each: set valid.
- `dirty_set0`, `dirty_set1` out 1 each: set dirty.
- `dirty_clr0`, `dirty_clr1` out 1 each: clear dirty.
- `data_src_sel` out 1: data array input select; 0 = byte-merged CPU write line, 1 = pmem line.
- `pmem_addr_sel` out 1: pmem address select; 0 = CPU line address, 1 = victim `{tag, set}` address.
- `hit_count`, `miss_count` out CNT_W each: statistics counters.

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. Outputs are Moore-style per state, with combinational qualification by `hit*` and `pmem_resp` as listed.
- **IDLE**
  - Any of `mem_read` or `mem_write` high → COMPARE.
  - All strobes are 0.
  - `pmem_resp` is ignored.
- **COMPARE, hit** (`hit0` or `hit1`)
  - `way_sel` = hit way; `hit0` takes priority if both are high.
  - Assert `mem_resp`.
  - Set `lru[set_idx]` = ~hit way, i.e. the next victim.
  - If `mem_write`: `data_loadW`=1, `dirty_setW`=1, `data_src_sel`=0.
  - `mem_write` has priority if both requests are high.
  - → IDLE.
- **COMPARE, miss**
  - Latch the victim: way0 if `!valid0`; else way1 if `!valid1`; else `lru[set_idx]`.
  - If the victim is valid and dirty → WRITEBACK, otherwise → ALLOCATE.
- **WRITEBACK**
  - `way_sel`=victim, `pmem_addr_sel`=1, `pmem_write`=1.
  - On `pmem_resp`: `dirty_clrV`=1 → ALLOCATE.
- **ALLOCATE**
  - `way_sel`=victim, `pmem_addr_sel`=0, `pmem_read`=1.
  - On `pmem_resp`: `data_src_sel`=1, and `data_loadV`, `tag_loadV`, `valid_loadV`, `dirty_clrV` all 1.
  - Set the refill flag, → COMPARE. The re-compare then hits and completes the read or write, including the merged write.
- **Counters**
  - Updated only on a COMPARE whose refill flag is 0: `hit_count`+1 on hit, `miss_count`+1 on miss.
  - The refill flag clears on leaving COMPARE.
  - Counters wrap modulo 2^CNT_W.
- **Reset**
  - `rst_n`=0 forces IDLE immediately.
  - The LRU array clears to 0 (victim way0), counters clear to 0, the refill flag and latched victim clear to 0.
  - All outputs are 0 at reset, including a mid-transfer `pmem_read`/`pmem_write`. The pmem side must tolerate the abandoned request.

## Timing
- Read or write hit: request seen in IDLE at cycle 0 → `mem_resp` in cycle 1, with the write strobe in the same cycle.
- Clean miss: COMPARE (c1) → ALLOCATE (c2 .. pmem_resp cycle R) → COMPARE (R+1) with `mem_resp`.
- Dirty miss: adds WRITEBACK ahead of ALLOCATE. `mem_resp` arrives in the cycle after the read `pmem_resp`.
- `pmem_read` and `pmem_write` are never high together, and drop in the cycle after `pmem_resp`.
- The requester must drop or replace its request in the cycle after `mem_resp`. IDLE samples in that cycle, and a still-high request starts a new access.
- `hit0`, `hit1`, `valid*`, `dirty*` and `set_idx` must be stable during COMPARE. The controller does not re-register them.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-ALLOCATE → `pmem_read`=0 immediately; after release, state IDLE, all strobes 0, both counters 0.
- **Read hit:** `mem_read`, `hit1`=1 in set 3 → `mem_resp` in cycle 1, `way_sel`=1, no data load, `lru[3]`=0, `hit_count`=1.
- **Write hit:** `mem_write`, `hit0`=1 → cycle 1 `data_load0`=`dirty_set0`=1, `data_src_sel`=0, `mem_resp`=1.
- **Clean miss, invalid way1:** `valid0`=1, `valid1`=0, `pmem_resp` after 5 cycles → ALLOCATE on way1, load strobes with `data_src_sel`=1, re-compare hit, `mem_resp` at cycle 8, `miss_count`=1, `hit_count`=0.
- **Dirty miss:** both ways valid, `lru`=0, `dirty0`=1 → `pmem_write` with `pmem_addr_sel`=1 until `pmem_resp`, `dirty_clr0`, then `pmem_read`, then `mem_resp`.
- **Counter wrap:** with CNT_W=4, 16 hits → `hit_count` reads 0.
